// File: rtl/vga_ram_arbiter_if.sv
// Bus bundle for the VGA/CPU/SRAM arbiter.
// The slave side is the arbiter; the master side is the requesters plus the SRAM pins.
`timescale 1ns/1ps
interface vga_ram_arbiter_if;
    logic        I_vga_req;
    logic [17:0] I_vga_adr;
    logic [15:0] O_vga_dat;
    logic        I_cpu_stb;
    logic        I_cpu_we;
    logic [17:0] I_cpu_adr;
    logic [15:0] I_cpu_dat;
    logic [1:0]  I_cpu_sel;
    logic [15:0] O_cpu_dat;
    logic        O_cpu_ack;
    logic [17:0] O_sram_adr;
    logic [15:0] O_sram_dat;
    logic        O_sram_dat_oe;
    logic [15:0] I_sram_dat;
    logic        O_sram_ce_n;
    logic        O_sram_oe_n;
    logic        O_sram_we_n;
    logic        O_sram_ub_n;
    logic        O_sram_lb_n;

    modport slave (
        input  I_vga_req, I_vga_adr, I_cpu_stb, I_cpu_we, I_cpu_adr, I_cpu_dat,
               I_cpu_sel, I_sram_dat,
        output O_vga_dat, O_cpu_dat, O_cpu_ack, O_sram_adr, O_sram_dat,
               O_sram_dat_oe, O_sram_ce_n, O_sram_oe_n, O_sram_we_n,
               O_sram_ub_n, O_sram_lb_n
    );

    modport master (
        output I_vga_req, I_vga_adr, I_cpu_stb, I_cpu_we, I_cpu_adr, I_cpu_dat,
               I_cpu_sel, I_sram_dat,
        input  O_vga_dat, O_cpu_dat, O_cpu_ack, O_sram_adr, O_sram_dat,
               O_sram_dat_oe, O_sram_ce_n, O_sram_oe_n, O_sram_we_n,
               O_sram_ub_n, O_sram_lb_n
    );
endinterface

// File: rtl/vga_ram_arbiter.sv
// Single-port async SRAM arbiter: VGA reads have absolute priority,
// CPU gets one-cycle read/write slots terminated by a one-cycle ack.
`timescale 1ns/1ps
module vga_ram_arbiter (
    input  logic               I_clk,
    input  logic               I_reset_n,
    vga_ram_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, ACK} cpu_state_t;

    cpu_state_t state_q, state_d;
    logic       vga_grant, cpu_grant;
    logic       vga_slot_q, cpu_rd_slot_q;

    assign vga_grant = bus.I_vga_req;
    assign cpu_grant = !bus.I_vga_req && (state_q == IDLE) && bus.I_cpu_stb;

    always_ff @(posedge I_clk) begin
        if (!I_reset_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cpu_grant) state_d = ACCESS;
            ACCESS:  state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.O_cpu_ack = (state_q == ACK);

    // Strobes are registered at the decision edge, so the slot occupies the
    // next cycle and read data is captured at the edge that ends it.
    always_ff @(posedge I_clk) begin
        if (!I_reset_n) begin
            vga_slot_q        <= 1'b0;
            cpu_rd_slot_q     <= 1'b0;
            bus.O_vga_dat     <= '0;
            bus.O_cpu_dat     <= '0;
            bus.O_sram_adr    <= '0;
            bus.O_sram_dat    <= '0;
            bus.O_sram_dat_oe <= 1'b0;
            bus.O_sram_ce_n   <= 1'b1;
            bus.O_sram_oe_n   <= 1'b1;
            bus.O_sram_we_n   <= 1'b1;
            bus.O_sram_ub_n   <= 1'b1;
            bus.O_sram_lb_n   <= 1'b1;
        end else begin
            vga_slot_q    <= vga_grant;
            cpu_rd_slot_q <= cpu_grant && !bus.I_cpu_we;
            if (vga_slot_q)    bus.O_vga_dat <= bus.I_sram_dat;
            if (cpu_rd_slot_q) bus.O_cpu_dat <= bus.I_sram_dat;

            bus.O_sram_dat_oe <= 1'b0;
            bus.O_sram_ce_n   <= 1'b1;
            bus.O_sram_oe_n   <= 1'b1;
            bus.O_sram_we_n   <= 1'b1;
            bus.O_sram_ub_n   <= 1'b1;
            bus.O_sram_lb_n   <= 1'b1;

            if (vga_grant) begin
                bus.O_sram_adr  <= bus.I_vga_adr;
                bus.O_sram_ce_n <= 1'b0;
                bus.O_sram_oe_n <= 1'b0;
                bus.O_sram_ub_n <= 1'b0;
                bus.O_sram_lb_n <= 1'b0;
            end else if (cpu_grant) begin
                bus.O_sram_adr  <= bus.I_cpu_adr;
                bus.O_sram_ce_n <= 1'b0;
                if (bus.I_cpu_we) begin
                    // sel=00 still runs the cycle; no byte lane is enabled.
                    bus.O_sram_we_n   <= 1'b0;
                    bus.O_sram_dat_oe <= 1'b1;
                    bus.O_sram_dat    <= bus.I_cpu_dat;
                    bus.O_sram_ub_n   <= ~bus.I_cpu_sel[1];
                    bus.O_sram_lb_n   <= ~bus.I_cpu_sel[0];
                end else begin
                    bus.O_sram_oe_n <= 1'b0;
                    bus.O_sram_ub_n <= 1'b0;
                    bus.O_sram_lb_n <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_ram_arbiter.sv
// Scoreboard bench for vga_ram_arbiter with a behavioural async SRAM model.
// Stimulus pushes expectations; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_vga_ram_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_ram_arbiter_if bus();

    vga_ram_arbiter dut (
        .I_clk     (clk),
        .I_reset_n (rst_n),
        .bus       (bus)
    );

    typedef struct {
        logic        we;
        logic [17:0] adr;
        logic [15:0] dat;
        int          cyc;
    } cpu_exp_t;

    logic [15:0] vga_q[$];
    cpu_exp_t    cpu_q[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ack_count = 0;
    int we_low = 0;
    logic [1:0] vp = '0;

    // SRAM model with a preload port usable while the DUT is in reset
    logic [15:0] mem [0:262143];
    logic        pl_we = 1'b0;
    logic [17:0] pl_adr = '0;
    logic [15:0] pl_dat = '0;

    assign bus.I_sram_dat = (!bus.O_sram_ce_n && !bus.O_sram_oe_n) ? mem[bus.O_sram_adr] : 16'hDEAD;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        vp  <= {vp[0] && rst_n, bus.I_vga_req && rst_n};
        if (!bus.O_sram_we_n) we_low <= we_low + 1;
        if (pl_we) mem[pl_adr] <= pl_dat;
        else if (!bus.O_sram_ce_n && !bus.O_sram_we_n) begin
            if (!bus.O_sram_ub_n) mem[bus.O_sram_adr][15:8] <= bus.O_sram_dat[15:8];
            if (!bus.O_sram_lb_n) mem[bus.O_sram_adr][7:0]  <= bus.O_sram_dat[7:0];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (vp[1]) begin
            if (vga_q.size() == 0) chk("vga_underflow", 32'(vga_q.size()), 32'd1);
            else chk("vga_dat", 32'(bus.O_vga_dat), 32'(vga_q.pop_front()));
        end
        if (bus.O_cpu_ack) begin
            ack_count++;
            if (cpu_q.size() == 0) chk("cpu_unexpected_ack", 32'(cpu_q.size()), 32'd1);
            else begin
                cpu_exp_t e;
                e = cpu_q.pop_front();
                chk("cpu_ack_cycle", 32'(cyc), 32'(e.cyc));
                if (e.we) chk("cpu_wr_mem", 32'(mem[e.adr]), 32'(e.dat));
                else      chk("cpu_rd_dat", 32'(bus.O_cpu_dat), 32'(e.dat));
            end
        end
        if (!bus.O_sram_we_n) chk("wr_slot_oe", {30'd0, bus.O_sram_oe_n, bus.O_sram_dat_oe}, 32'd3);
        if (!bus.O_sram_oe_n) chk("rd_slot_dat_oe", 32'(bus.O_sram_dat_oe), 32'd0);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic cpu_xfer(input logic we, input logic [17:0] adr, input logic [15:0] dat,
                            input logic [1:0] sel, input logic [15:0] exp, input int lat);
        cpu_q.push_back('{we, adr, exp, cyc + lat});
        bus.I_cpu_we  = we;
        bus.I_cpu_adr = adr;
        bus.I_cpu_dat = dat;
        bus.I_cpu_sel = sel;
        bus.I_cpu_stb = 1'b1;
        for (int n = 0; n < 20 && !bus.O_cpu_ack; n++) step(1);
        chk("cpu_ack_seen", 32'(bus.O_cpu_ack), 32'd1);
        bus.I_cpu_stb = 1'b0;
        step(1);
    endtask

    logic [17:0] pl_a [10] = '{18'h100, 18'h101, 18'h102, 18'h103, 18'h3FFFF,
                               18'h200, 18'h201, 18'h202, 18'h203, 18'h500};
    logic [15:0] pl_d [10] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h1234,
                               16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'h5A5A};

    initial begin
        int acks_before;
        int we_before;
        bus.I_vga_req = 1'b1;
        bus.I_vga_adr = 18'h0;
        bus.I_cpu_stb = 1'b1;
        bus.I_cpu_we  = 1'b0;
        bus.I_cpu_adr = 18'h0;
        bus.I_cpu_dat = 16'h0;
        bus.I_cpu_sel = 2'b00;

        // Reset with both requesters active; SRAM preload runs meanwhile
        step(1);
        for (int i = 0; i < 10; i++) begin
            pl_we = 1'b1; pl_adr = pl_a[i]; pl_dat = pl_d[i];
            step(1);
        end
        pl_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_strobes", {27'd0, bus.O_sram_ce_n, bus.O_sram_oe_n, bus.O_sram_we_n,
                                bus.O_sram_ub_n, bus.O_sram_lb_n}, 32'h1F);
            chk("rst_ack", 32'(bus.O_cpu_ack), 32'd0);
            chk("rst_vga_dat", 32'(bus.O_vga_dat), 32'd0);
            chk("rst_adr_oe", {13'd0, bus.O_sram_adr, bus.O_sram_dat_oe}, 32'd0);
        end
        step(1);
        rst_n = 1'b1;
        bus.I_vga_req = 1'b0;
        bus.I_cpu_stb = 1'b0;
        step(2);

        // VGA stream, one word per cycle
        for (int i = 0; i < 4; i++) begin
            bus.I_vga_req = 1'b1;
            bus.I_vga_adr = 18'h100 + 18'(i);
            vga_q.push_back(16'(i));
            step(1);
        end
        bus.I_vga_req = 1'b0;
        step(4);

        // Byte-masked write, masked-off write, then read back
        we_before = we_low;
        cpu_xfer(1'b1, 18'h3FFFF, 16'hBEEF, 2'b01, 16'h12EF, 2);
        chk("we_pulse_len", 32'(we_low - we_before), 32'd1);
        we_before = we_low;
        cpu_xfer(1'b1, 18'h3FFFF, 16'hFFFF, 2'b00, 16'h12EF, 2);
        chk("we_pulse_sel00", 32'(we_low - we_before), 32'd1);
        cpu_xfer(1'b0, 18'h3FFFF, 16'h0000, 2'b11, 16'h12EF, 2);
        step(2);

        // Same-edge conflict: VGA first, CPU one slot later
        bus.I_vga_req = 1'b1;
        bus.I_vga_adr = 18'h101;
        vga_q.push_back(16'h0001);
        fork
            cpu_xfer(1'b0, 18'h500, 16'h0000, 2'b11, 16'h5A5A, 3);
            begin step(1); bus.I_vga_req = 1'b0; end
        join
        step(2);

        // Alternating VGA with a pending CPU read
        fork
            cpu_xfer(1'b0, 18'h500, 16'h0000, 2'b11, 16'h5A5A, 3);
            begin
                for (int i = 0; i < 4; i++) begin
                    bus.I_vga_req = (i % 2 == 0);
                    bus.I_vga_adr = 18'h200 + 18'(i);
                    if (i % 2 == 0) vga_q.push_back(16'hA000 + 16'(i));
                    step(1);
                end
                bus.I_vga_req = 1'b0;
            end
        join
        step(3);

        // Reset during ACCESS drops the transfer
        bus.I_cpu_we  = 1'b0;
        bus.I_cpu_adr = 18'h500;
        bus.I_cpu_stb = 1'b1;
        step(1);
        rst_n = 1'b0;
        bus.I_cpu_stb = 1'b0;
        step(1);
        rst_n = 1'b1;
        acks_before = ack_count;
        chk("rst_mid_ce_n", 32'(bus.O_sram_ce_n), 32'd1);
        step(4);
        chk("rst_mid_no_ack", 32'(ack_count), 32'(acks_before));
        cpu_xfer(1'b0, 18'h500, 16'h0000, 2'b11, 16'h5A5A, 2);
        step(4);

        chk("vga_q_drained", 32'(vga_q.size()), 32'd0);
        chk("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
        chk("total_acks", 32'(ack_count), 32'd6);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule

// File: doc/vga_ram_arbiter.md
# vga_ram_arbiter

Shares the single 16-bit asynchronous video SRAM between two requesters: the VGA pixel pipes (fixed-latency reads, absolute priority) and the CPU bus port (variable-latency, ack-terminated reads and byte-masked writes). Each rising edge schedules the SRAM access for the following cycle. All SRAM control, address and data outputs are registered. The block sits between the `vga` block's `O_ram_req`/`O_ram_adr`/`I_ram_dat` port and the board SRAM pins; the CPU bus bridge attaches to its CPU side.

## Interface
- No parameters. Address width is 18 bits (256K x 16) and data width is 16 bits, both fixed.
- I_clk  in  1  memory/VGA clock. Single clock domain.
- I_reset_n  in  1  reset: synchronous, active-low.
- I_vga_req  in  1  VGA read request, sampled every edge.
- I_vga_adr  in  18  VGA word address.
- O_vga_dat  out  16  VGA read data. Valid exactly 2 cycles after the sampling edge of `I_vga_req`.
- I_cpu_stb  in  1  CPU request. Held high until `O_cpu_ack`.
- I_cpu_we  in  1  1 = write, 0 = read.
- I_cpu_adr  in  18  CPU word address.
- I_cpu_dat  in  16  CPU write data.
- I_cpu_sel  in  2  byte enables; [1] = upper byte, [0] = lower byte.
- O_cpu_dat  out  16  CPU read data. Valid while `O_cpu_ack` is high.
- O_cpu_ack  out  1  one-cycle completion pulse.
- O_sram_adr  out  18  SRAM address.
- O_sram_dat  out  16  SRAM write data.
- O_sram_dat_oe  out  1  tristate enable for the data pins (1 = drive).
- I_sram_dat  in  16  SRAM read data.
- O_sram_ce_n, O_sram_oe_n, O_sram_we_n, O_sram_ub_n, O_sram_lb_n  out  1 each  active-low SRAM strobes.

## Operation
- **Slot decision** is made at every rising edge, for the next cycle, in this priority order:
  1. If `I_vga_req`=1: VGA read slot.
  2. Else if CPU FSM is IDLE and `I_cpu_stb`=1: CPU slot.
  3. Else: idle slot.
- **VGA read slot:**
  - `O_sram_adr` = `I_vga_adr`.
  - ce_n=0, oe_n=0, we_n=1, ub_n=lb_n=0, dat_oe=0.
  - `I_sram_dat` is captured into `O_vga_dat` at the end of the slot.
- **CPU read slot:**
  - Same strobes as a VGA read.
  - Address = `I_cpu_adr`.
  - Data is captured into `O_cpu_dat` at the end of the slot.
- **CPU write slot:**
  - ce_n=0, oe_n=1, we_n=0, dat_oe=1.
  - `O_sram_dat` = `I_cpu_dat`.
  - ub_n = ~sel[1], lb_n = ~sel[0].
  - sel=2'b00 still performs the cycle: nothing is written, and the CPU is acked.
- **Idle slot:**
  - ce_n=oe_n=we_n=ub_n=lb_n=1, dat_oe=0.
  - Address holds its last value.
- **CPU FSM** (states IDLE, ACCESS, ACK):
  - IDLE -> ACCESS on a granted CPU slot.
  - ACCESS -> ACK unconditionally.
  - ACK -> IDLE unconditionally. `O_cpu_ack`=1 only in ACK.
  - A request is never re-issued during ACCESS or ACK, even with `I_cpu_stb` held high.
- **Preemption:** a CPU access is one cycle, so it is never interrupted. VGA only delays the *start* of a CPU access.
  - A VGA request at the same edge as the CPU grant edge wins; the CPU waits in IDLE.
  - VGA slots are granted freely while the CPU FSM is in ACCESS or ACK.
- **Starvation:** continuous `I_vga_req` starves the CPU indefinitely. The VGA pixel pipes guarantee `I_vga_req` duty ≤ 50%, which bounds the CPU wait to ≤ 2 cycles per blocking VGA run of length 1.
- `O_vga_dat` and `O_cpu_dat` hold their value between captures.

## Timing
- **Reset** (`I_reset_n`=0 at an edge), outputs after that edge:
  - All SRAM strobes = 1, dat_oe = 0, `O_sram_adr` = 0, `O_sram_dat` = 0.
  - `O_vga_dat` = 0, `O_cpu_dat` = 0, `O_cpu_ack` = 0, FSM = IDLE.
- **Reset mid-operation:** an in-flight CPU access is dropped without an ack. The CPU side must re-issue after reset.
- **VGA latency:**
  - Request sampled at edge n; SRAM slot runs during cycle n+1; `O_vga_dat` is valid from edge n+2 onward (latency 2, fixed).
  - Back-to-back VGA requests give one word per cycle.
- **CPU latency:** grant at edge n, access during n+1, `O_cpu_ack`=1 during n+2. Minimum 2 cycles from `I_cpu_stb` sampled to ack.
- **Write data path:** the write data pins are driven only during the write slot. A read slot may follow a write slot directly; the registered dat_oe drops at the same edge at which oe_n falls.

## Test plan
- **Reset:** hold `I_reset_n`=0 for 3 cycles with `I_vga_req`=1 and `I_cpu_stb`=1 -> all strobes stay 1, `O_cpu_ack`=0, `O_vga_dat`=0.
- **VGA stream:** SRAM model preloaded with mem[0x100+i]=i; `I_vga_req`=1 for 4 cycles at adr 0x100..0x103 -> `O_vga_dat`=0,1,2,3 at edges n+2..n+5.
- **CPU write then read:**
  - Write adr 0x3FFFF, dat 0xBEEF, sel=2'b01 over old 0x1234 -> ack after 2 cycles, mem=0x12EF, we_n low for exactly one cycle.
  - Then read the same address -> `O_cpu_dat`=0x12EF with ack.
- **Conflict:** `I_cpu_stb` and `I_vga_req` rise at the same edge -> VGA slot first, CPU slot next cycle, CPU ack 3 cycles after stb. `O_vga_dat` latency is still 2.
- **Alternating VGA requests (1,0,1,0) with a CPU read pending** -> the CPU takes the first free slot, every VGA datum arrives at latency 2, and exactly one ack is produced.
- **Reset asserted in the ACCESS cycle** -> no ack. The next request completes normally.
